// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: fetch-stage state encoding and
// common instruction/PC constants.
package mips_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DROP  = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/if_fetch_stage_pc_next_mux.sv
// Redirect target selection for the fetch stage: branch beats jump and the
// chosen target is forced onto a word boundary.
module pc_next_mux (
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   output logic        redirect,
   output logic [31:0] target
);

   logic [31:0] selected;

   assign redirect = branch_taken | jump;
   assign selected = branch_taken ? branch_target : jump_target;
   assign target   = {selected[31:2], 2'b00};

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory
// handshake and hands instructions (or NOP bubbles) to the IF/ID register.
module if_fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PCplus4_IF,
   output logic [31:0] Instr_IF
);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  instr_buf;
   logic [31:0]  redirect_pc;
   logic         redirect;
   logic [31:0]  target;

   pc_next_mux u_pc_next_mux (
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .redirect      (redirect),
      .target        (target)
   );

   // A redirect while a request is outstanding cannot move the address, so it
   // is parked in redirect_pc and the eventual response is thrown away (DROP).
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         state       <= FETCH;
         instr_buf   <= NOP_INSTR;
         redirect_pc <= 32'h0;
      end else begin
         case (state)
            FETCH: begin
               if (imem_ready) begin
                  if (redirect) begin
                     pc <= target;
                  end else if (stall) begin
                     instr_buf <= imem_rdata;
                     state     <= HOLD;
                  end else begin
                     pc <= pc + PC_INC;
                  end
               end else if (redirect) begin
                  redirect_pc <= target;
                  state       <= DROP;
               end
            end
            HOLD: begin
               if (redirect) begin
                  pc    <= target;
                  state <= FETCH;
               end else if (!stall) begin
                  pc    <= pc + PC_INC;
                  state <= FETCH;
               end
            end
            DROP: begin
               if (imem_ready) begin
                  pc    <= redirect ? target : redirect_pc;
                  state <= FETCH;
               end else if (redirect) begin
                  redirect_pc <= target;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

   // Redirect squashes whatever would otherwise be presented downstream.
   always_comb begin
      imem_req   = !rst && (state != HOLD);
      imem_addr  = pc;
      PCplus4_IF = rst ? (RESET_PC + PC_INC) : (pc + PC_INC);
      Instr_IF   = NOP_INSTR;
      if (!rst) begin
         case (state)
            FETCH:   if (imem_ready && !redirect) Instr_IF = imem_rdata;
            HOLD:    if (!redirect) Instr_IF = instr_buf;
            default: Instr_IF = NOP_INSTR;
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios then random
// stimulus, every cycle compared against a transaction-level fetch model.
module tb_if_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] PCplus4_IF;
   logic [31:0] Instr_IF;

   int compared;
   int mismatched;

   // Model state: where the stage points, whether a word is parked waiting
   // for the stall to clear, and whether an in-flight response is doomed.
   logic [31:0] m_pc;
   logic [31:0] m_word;
   logic [31:0] m_pending;
   bit          m_parked;
   bit          m_doomed;
   bit          m_known;

   if_fetch_stage #(.RESET_PC(RST_PC)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rdata    (imem_rdata),
      .PCplus4_IF    (PCplus4_IF),
      .Instr_IF      (Instr_IF)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (branch_taken && jump)
         $error("[TB] illegal stimulus: branch_taken and jump together");
   end

   function automatic logic [31:0] memWord(input logic [31:0] addr);
      return addr ^ 32'hC0DE_0001;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // One pipeline cycle: drive inputs, check against the model mid-cycle,
   // advance the model, then move to just after the next rising edge.
   task automatic applyStimulus(input bit r, input bit st, input bit br,
                                input logic [31:0] bt, input bit jp,
                                input logic [31:0] jt, input bit rdy);
      bit          redir;
      logic [31:0] tgt;
      logic [31:0] exp_instr;
      rst           = r;
      stall         = st;
      branch_taken  = br;
      branch_target = bt;
      jump          = jp;
      jump_target   = jt;
      imem_ready    = rdy;
      imem_rdata    = rdy ? memWord(imem_addr) : $urandom;
      redir = br || jp;
      tgt   = br ? bt : jt;
      tgt   = tgt & 32'hFFFF_FFFC;
      #4;
      if (r) begin
         checkOutput("req_rst", {31'd0, imem_req}, 32'd0);
         checkOutput("instr_rst", Instr_IF, 32'd0);
         checkOutput("pc4_rst", PCplus4_IF, RST_PC + 32'd4);
         m_pc      = RST_PC;
         m_parked  = 0;
         m_doomed  = 0;
         m_word    = 0;
         m_pending = 0;
         m_known   = 1;
      end else if (m_known) begin
         if (m_doomed)      exp_instr = 32'h0;
         else if (m_parked) exp_instr = redir ? 32'h0 : m_word;
         else               exp_instr = (rdy && !redir) ? memWord(m_pc) : 32'h0;
         checkOutput("req", {31'd0, imem_req}, {31'd0, !m_parked});
         checkOutput("addr", imem_addr, m_pc);
         checkOutput("pc4", PCplus4_IF, m_pc + 32'd4);
         checkOutput("instr", Instr_IF, exp_instr);
         if (m_doomed) begin
            if (redir) m_pending = tgt;
            if (rdy) begin
               m_pc     = m_pending;
               m_doomed = 0;
            end
         end else if (m_parked) begin
            if (redir) begin
               m_pc = tgt; m_parked = 0;
            end else if (!st) begin
               m_pc = m_pc + 32'd4; m_parked = 0;
            end
         end else if (rdy) begin
            if (redir)   m_pc = tgt;
            else if (st) begin m_word = memWord(m_pc); m_parked = 1; end
            else         m_pc = m_pc + 32'd4;
         end else if (redir) begin
            m_pending = tgt; m_doomed = 1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      compared = 0; mismatched = 0; m_known = 0;
      m_pc = 0; m_word = 0; m_pending = 0; m_parked = 0; m_doomed = 0;
      rst = 1; stall = 0; branch_taken = 0; branch_target = 0;
      jump = 0; jump_target = 0; imem_ready = 0; imem_rdata = 0;
      #1;
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 1);
      // Zero-wait streaming from the reset PC.
      repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 1);
      // Stall held three cycles while the word at 0x200 returns.
      applyStimulus(0, 0, 0, 0, 1, 32'h200, 1);
      repeat (3) applyStimulus(0, 1, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      // Taken branch at 0x300, with unaligned target bits to be masked.
      applyStimulus(0, 0, 0, 0, 1, 32'h300, 1);
      applyStimulus(0, 0, 1, 32'h403, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      // Jump during a waiting fetch at 0x500: response is dropped.
      applyStimulus(0, 0, 0, 0, 1, 32'h500, 1);
      applyStimulus(0, 0, 0, 0, 1, 32'h800, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      // Two memory wait cycles then the word.
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      // PC wrap at the top of the address space.
      applyStimulus(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      // Reset while a dropped response is still outstanding.
      applyStimulus(0, 0, 0, 0, 1, 32'h900, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 400; i++) begin
         bit r, st, br, jp, rdy;
         int pick;
         r    = ($urandom_range(0, 99) == 0);
         st   = ($urandom_range(0, 3) == 0);
         rdy  = ($urandom_range(0, 9) < 6);
         pick = $urandom_range(0, 19);
         br   = (pick == 0 || pick == 1);
         jp   = (pick == 2 || pick == 3);
         applyStimulus(r, st, br, $urandom, jp, $urandom, rdy);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
